// File: rtl/reg_dest_queue_pkg.sv
// Shared select codes and fixed register indices for the destination
// selector and its pending-write queue.
package reg_dest_pkg;

    // Destination select codes driven by the control unit; 101-111 pick $zero
    typedef enum logic [2:0] {
        SEL_RT = 3'b000,
        SEL_RD = 3'b001,
        SEL_SP = 3'b010,
        SEL_FP = 3'b011,
        SEL_RA = 3'b100
    } regdest_sel_e;

    // Architectural register numbers with a fixed role
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_FP   = 30;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/reg_dest_queue_if.sv
// Bundle of the selector, issue, writeback and hazard-query signals that run
// between the control unit and the register-destination queue.
interface reg_dest_queue_if #(
    parameter int REG_W = 5,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [2:0]       seletor_regdest;
    logic [REG_W-1:0] RT;
    logic [REG_W-1:0] RD;
    logic [REG_W-1:0] mux_RegDest_output;
    logic             issue_valid;
    logic             issue_ready;
    logic             wb_valid;
    logic             pending_valid;
    logic [REG_W-1:0] wb_dest;
    logic [REG_W-1:0] query_reg;
    logic             query_busy;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    // Control-unit side: selects, issues, retires and queries
    modport master (
        output seletor_regdest, RT, RD, issue_valid, wb_valid, query_reg,
        input  mux_RegDest_output, issue_ready, pending_valid, wb_dest,
               query_busy, count, overflow, underflow
    );

    // Queue side
    modport slave (
        input  seletor_regdest, RT, RD, issue_valid, wb_valid, query_reg,
        output mux_RegDest_output, issue_ready, pending_valid, wb_dest,
               query_busy, count, overflow, underflow
    );

endinterface

// File: rtl/reg_dest_queue_select.sv
// Combinational write-destination selector: RT, RD or one of the fixed
// registers ($sp, $fp, $ra); unused codes fall back to $zero.
module reg_dest_select
    import reg_dest_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [2:0]       sel,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] dest
);

    // Pure mux; fixed indices are resized to the register index width
    always_comb begin
        dest = REG_W'(REG_ZERO);
        case (sel)
            SEL_RT:  dest = rt;
            SEL_RD:  dest = rd;
            SEL_SP:  dest = REG_W'(REG_SP);
            SEL_FP:  dest = REG_W'(REG_FP);
            SEL_RA:  dest = REG_W'(REG_RA);
            default: dest = REG_W'(REG_ZERO);
        endcase
    end

endmodule

// File: rtl/reg_dest_queue.sv
// In-order pending-write queue of register destinations. Issued destinations
// are appended at the tail, long-latency writebacks retire the head, and the
// hazard query reports whether a register still has a write outstanding.
module reg_dest_queue
    import reg_dest_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    reg_dest_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_W-1:0] sel_dest;
    logic [REG_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             overflow_q;
    logic             underflow_q;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] match_vec;

    reg_dest_select #(
        .REG_W (REG_W)
    ) u_select (
        .sel  (bus.seletor_regdest),
        .rt   (bus.RT),
        .rd   (bus.RD),
        .dest (sel_dest)
    );

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // A pop frees the head slot in the same edge, so an issue alongside a
    // pop is taken even at full; $zero destinations are accepted but never stored
    assign do_pop  = bus.wb_valid && !empty;
    assign do_push = bus.issue_valid && (!full || do_pop) && (sel_dest != '0);

    // Entry storage and tail pointer: write the selected index on a push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            tail <= '0;
        end else if (do_push) begin
            entries[tail] <= sel_dest;
            tail          <= tail + PTR_W'(1);
        end
    end

    // Head pointer advances on each retired writeback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
        end else if (do_pop) begin
            head <= head + PTR_W'(1);
        end
    end

    // Occupancy tracks push minus pop; full and empty are derived from it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.issue_valid && full && !bus.wb_valid) begin
                overflow_q <= 1'b1;
            end
            if (bus.wb_valid && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // An entry is live when its distance from the head is below the count
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [PTR_W-1:0] age;
        assign age          = PTR_W'(g) - head;
        assign valid_vec[g] = ({1'b0, age} < cnt);
        assign match_vec[g] = (entries[g] == bus.query_reg);
    end

    assign bus.mux_RegDest_output = sel_dest;
    assign bus.issue_ready        = !full;
    assign bus.pending_valid      = !empty;
    assign bus.wb_dest            = empty ? '0 : entries[head];
    assign bus.count              = cnt;
    assign bus.overflow           = overflow_q;
    assign bus.underflow          = underflow_q;
    assign bus.query_busy         = (bus.query_reg != '0) && |(valid_vec & match_vec);

endmodule
